tc_parade_multi: RTL and testbench

Parametrised successor to the two-road parade traffic controller. It drives NUM_DIR approaches from one timed finite-state machine (FSM) with:
- a minimum green time,
- a counted yellow phase,
- an optional all-red clearance,
- request-driven skipping of idle approaches,
- a parade mode that routes the green to a configurable approach and holds it there.

It sits between the debounced sensor/button inputs and the lamp drivers of the intersection top level.

---
 rtl/tc_parade_multi.sv | 156 +++++++++++++++
 tb/tb_tc_parade_multi.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tc_parade_multi.sv
`default_nettype none
// ============================================================================
// Module  : tc_parade_multi
// Brief   : N-approach traffic controller with min-green, yellow, all-red
//           clearance, request skipping and a parade hold mode.
// Revision: 1.0
// ============================================================================
module tc_parade_multi #(
    parameter  int NUM_DIR        = 2,
    parameter  int CNT_W          = 8,
    parameter  int MIN_GREEN      = 5,
    parameter  int YELLOW_CYCLES  = 3,
    parameter  int ALL_RED_CYCLES = 1,
    parameter  int PARADE_DIR     = 1,
    localparam int IW             = $clog2(NUM_DIR)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 P,
    input  logic                 R,
    input  logic [NUM_DIR-1:0]   T,
    output logic [3*NUM_DIR-1:0] L,
    output logic [IW-1:0]        ACTIVE,
    output logic                 MODE
);

    typedef enum logic [1:0] {
        S_GREEN  = 2'd0,
        S_YELLOW = 2'd1,
        S_ALLRED = 2'd2
    } phase_t;

    localparam logic [CNT_W-1:0] c_MG_LAST  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] c_YEL_LAST = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_AR_LAST  =
        CNT_W'((ALL_RED_CYCLES > 0) ? (ALL_RED_CYCLES - 1) : 0);
    localparam logic             c_HAS_AR   = (ALL_RED_CYCLES > 0);
    localparam logic [IW-1:0]    c_PARADE   = IW'(PARADE_DIR);
    localparam logic [IW-1:0]    c_LAST_DIR = IW'(NUM_DIR - 1);
    localparam logic [CNT_W-1:0] c_TMAX     = '1;

    phase_t             r_phase;
    logic [IW-1:0]      r_cur;
    logic [IW-1:0]      r_nxt;
    logic [CNT_W-1:0]   r_timer;
    logic               r_mode;

    phase_t             w_phase_nxt;
    logic [IW-1:0]      w_cur_nxt;
    logic [IW-1:0]      w_nxt_nxt;
    logic [CNT_W-1:0]   w_timer_nxt;
    logic               w_mode_nxt;

    logic [IW-1:0]      w_cur_inc;
    logic [IW-1:0]      w_scan_idx;
    logic [IW-1:0]      w_scan_try;
    int                 w_scan_sum;
    logic               w_hold;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_phase <= S_GREEN;
            r_cur   <= '0;
            r_nxt   <= '0;
            r_timer <= '0;
            r_mode  <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_cur   <= w_cur_nxt;
            r_nxt   <= w_nxt_nxt;
            r_timer <= w_timer_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    // Scan from the farthest candidate toward cur+1 so the nearest request wins.
    always_comb begin
        w_cur_inc  = (r_cur == c_LAST_DIR) ? '0 : r_cur + IW'(1);
        w_scan_idx = w_cur_inc;
        w_scan_sum = 0;
        w_scan_try = '0;
        for (int k = NUM_DIR - 1; k >= 1; k--) begin
            w_scan_sum = int'(r_cur) + k;
            if (w_scan_sum >= NUM_DIR) begin
                w_scan_sum = w_scan_sum - NUM_DIR;
            end
            w_scan_try = IW'(w_scan_sum);
            if (T[w_scan_try]) begin
                w_scan_idx = w_scan_try;
            end
        end
    end

    assign w_hold = (r_timer < c_MG_LAST)
                 || (r_mode && (r_cur == c_PARADE))
                 || (!r_mode && T[r_cur]);

    always_comb begin
        w_phase_nxt = r_phase;
        w_cur_nxt   = r_cur;
        w_nxt_nxt   = r_nxt;
        w_timer_nxt = (r_timer == c_TMAX) ? r_timer : r_timer + CNT_W'(1);
        w_mode_nxt  = r_mode;

        if (P && !R) begin
            w_mode_nxt = 1'b1;
        end else if (R && !P) begin
            w_mode_nxt = 1'b0;
        end

        case (r_phase)
            S_GREEN: begin
                if (!w_hold) begin
                    w_phase_nxt = S_YELLOW;
                    w_timer_nxt = '0;
                    w_nxt_nxt   = r_mode ? c_PARADE : w_scan_idx;
                end
            end
            S_YELLOW: begin
                if (r_timer == c_YEL_LAST) begin
                    w_timer_nxt = '0;
                    if (c_HAS_AR) begin
                        w_phase_nxt = S_ALLRED;
                    end else begin
                        w_phase_nxt = S_GREEN;
                        w_cur_nxt   = r_nxt;
                    end
                end
            end
            S_ALLRED: begin
                if (r_timer == c_AR_LAST) begin
                    w_phase_nxt = S_GREEN;
                    w_cur_nxt   = r_nxt;
                    w_timer_nxt = '0;
                end
            end
            default: begin
                w_phase_nxt = S_GREEN;
                w_timer_nxt = '0;
            end
        endcase
    end

    for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_lamp
        logic w_own;
        assign w_own         = (r_cur == IW'(gi));
        assign L[3*gi + 2]   = w_own && (r_phase == S_GREEN);
        assign L[3*gi + 1]   = w_own && (r_phase == S_YELLOW);
        assign L[3*gi]       = !(w_own && ((r_phase == S_GREEN) || (r_phase == S_YELLOW)));
    end

    assign ACTIVE = r_cur;
    assign MODE   = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_tc_parade_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_tc_parade_multi
// Brief   : Scoreboard bench for tc_parade_multi (4 approaches, parade on 1).
// Revision: 1.0
// ============================================================================
module tb_tc_parade_multi;

    localparam int PH_G = 0;
    localparam int PH_Y = 1;
    localparam int PH_A = 2;
    localparam logic [11:0] c_RST_L = 12'b001_001_001_100;

    logic        CLK;
    logic        RESET;
    logic        P;
    logic        R;
    logic [3:0]  T;
    logic [11:0] L;
    logic [1:0]  ACTIVE;
    logic        MODE;

    typedef struct packed {
        logic [11:0] l;
        logic [1:0]  a;
        logic        m;
    } exp_t;

    exp_t  q[$];
    string qn[$];
    int    checks = 0;
    int    errors = 0;

    tc_parade_multi #(
        .NUM_DIR       (4),
        .CNT_W         (8),
        .MIN_GREEN     (5),
        .YELLOW_CYCLES (3),
        .ALL_RED_CYCLES(1),
        .PARADE_DIR    (1)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .P     (P),
        .R     (R),
        .T     (T),
        .L     (L),
        .ACTIVE(ACTIVE),
        .MODE  (MODE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [11:0] lamp_exp(input int ph, input int c);
        logic [11:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            if (i == c && ph == PH_G)      v[3*i + 2] = 1'b1;
            else if (i == c && ph == PH_Y) v[3*i + 1] = 1'b1;
            else                           v[3*i]     = 1'b1;
        end
        return v;
    endfunction

    task automatic push_raw(input logic [11:0] l, input int c, input logic m, input string nm);
        exp_t e;
        e.l = l;
        e.a = 2'(c);
        e.m = m;
        q.push_back(e);
        qn.push_back(nm);
    endtask

    task automatic push(input int ph, input int c, input logic m, input string nm);
        push_raw(lamp_exp(ph, c), c, m, nm);
    endtask

    task automatic chk(input int ph, input int c, input logic m, input string nm);
        @(posedge CLK);
        #1;
        push(ph, c, m, nm);
    endtask

    // Yellow always lasts 3 cycles and all-red 1 cycle with these parameters.
    task automatic phase_run(input int c, input int g, input logic m, input string nm);
        repeat (g) chk(PH_G, c, m, {nm, "_green"});
        repeat (3) chk(PH_Y, c, m, {nm, "_yellow"});
        chk(PH_A, c, m, {nm, "_allred"});
    endtask

    task automatic do_reset(input logic [3:0] tv, input string nm);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        push_raw(c_RST_L, 0, 1'b0, {nm, "_rst"});
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        T     = tv;
        push(PH_G, 0, 1'b0, {nm, "_rel"});
    endtask

    always @(negedge CLK) begin
        if (q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = q.pop_front();
            nm = qn.pop_front();
            checks++;
            if (L !== e.l || ACTIVE !== e.a || MODE !== e.m) begin
                errors++;
                $display("FAIL %s @%0t: got L=%b ACTIVE=%0d MODE=%b, want L=%b ACTIVE=%0d MODE=%b",
                         nm, $time, L, ACTIVE, MODE, e.l, e.a, e.m);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b0;
        P     = 1'b0;
        R     = 1'b0;
        T     = 4'b1111;

        // Reset holds approach 0 green regardless of sensors.
        repeat (3) begin
            @(posedge CLK);
            #1;
            push_raw(c_RST_L, 0, 1'b0, "reset_hold");
        end
        RESET = 1'b1;
        T     = 4'b0001;
        repeat (4) chk(PH_G, 0, 1'b0, "release_green0");

        // Minimum green then skip idle approach 1.
        do_reset(4'b0100, "mingreen");
        phase_run(0, 4, 1'b0, "mingreen0");
        chk(PH_G, 2, 1'b0, "skip_to_2");

        // Full rotation with no requests.
        do_reset(4'b0000, "rot");
        phase_run(0, 4, 1'b0, "rot0");
        chk(PH_G, 1, 1'b0, "rot_g1");
        phase_run(1, 4, 1'b0, "rot1");
        chk(PH_G, 2, 1'b0, "rot_g2");
        phase_run(2, 4, 1'b0, "rot2");
        chk(PH_G, 3, 1'b0, "rot_g3");
        phase_run(3, 4, 1'b0, "rot3");
        chk(PH_G, 0, 1'b0, "rot_wrap_g0");

        // Request on 3, then parade entry while 3 is green and still requesting.
        T = 4'b1000;
        phase_run(0, 4, 1'b0, "toward3");
        chk(PH_G, 3, 1'b0, "g3_entry");
        P = 1'b1;
        chk(PH_G, 3, 1'b1, "parade_set");
        P = 1'b0;
        phase_run(3, 3, 1'b1, "parade_leave3");
        chk(PH_G, 1, 1'b1, "parade_g1");
        T = 4'b0000;
        repeat (55) chk(PH_G, 1, 1'b1, "parade_hold");

        // Simultaneous P and R leave mode unchanged; R alone releases.
        P = 1'b1;
        R = 1'b1;
        chk(PH_G, 1, 1'b1, "pr_both");
        P = 1'b0;
        R = 1'b0;
        chk(PH_G, 1, 1'b1, "pr_after");
        R = 1'b1;
        chk(PH_G, 1, 1'b0, "release_mode");
        R = 1'b0;
        repeat (3) chk(PH_Y, 1, 1'b0, "release_yellow");
        chk(PH_A, 1, 1'b0, "release_allred");
        chk(PH_G, 2, 1'b0, "release_g2");

        // Mode set on a non-parade approach, then reset during its yellow.
        P = 1'b1;
        chk(PH_G, 2, 1'b1, "g2_mode");
        P = 1'b0;
        repeat (3) chk(PH_G, 2, 1'b1, "g2_mode_hold");
        chk(PH_Y, 2, 1'b1, "y2");
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        push_raw(c_RST_L, 0, 1'b0, "reset_mid_yellow");
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        push(PH_G, 0, 1'b0, "post_reset_g0");
        chk(PH_G, 0, 1'b0, "post_reset_g0_b");

        repeat (2) @(negedge CLK);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
